// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: length-prefixed big-endian byte stream -> word writes.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic        ByteValid,
  input  logic [7:0]  ByteData,
  output logic        ByteReady,
  output logic        MemWrite,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        CpuHold,
  output logic        Done,
  output logic        Error
);
  localparam logic [31:0] DEPTH_U = DEPTH;

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE} state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t TAIL = CHECK;
`else
  localparam state_t TAIL = DONE;
`endif

  state_t       state, state_nxt;
  logic [15:0]  len, idx;
  logic [1:0]   bcnt;
  logic [23:0]  sr;
  logic [31:0]  mem_addr, mem_data;
  logic         err;
  logic         accept, in_range, start_ok;
  logic [15:0]  len_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]   chk;
`endif

  assign accept   = ByteValid & ByteReady;
  assign in_range = {16'h0, idx} < DEPTH_U;
  assign start_ok = Start & ((state == IDLE) | (state == DONE));
  assign len_full = {len[15:8], ByteData};

  always_comb begin
    state_nxt = state;
    ByteReady = 1'b0;
    case (state)
      IDLE:   if (Start) state_nxt = LEN_HI;
      LEN_HI: begin
        ByteReady = 1'b1;
        if (accept) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        ByteReady = 1'b1;
        if (accept) state_nxt = (len_full == 16'h0) ? TAIL : DATA;
      end
      DATA: begin
        ByteReady = 1'b1;
        if (accept && bcnt == 2'd3) state_nxt = WRITE;
      end
      WRITE:  state_nxt = (idx == len - 16'd1) ? TAIL : DATA;
      CHECK: begin
        ByteReady = 1'b1;
        if (accept) state_nxt = DONE;
      end
      DONE:   if (Start) state_nxt = LEN_HI;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Address/data registers load on the 4th byte only for in-range words, so they
  // hold the last real write through out-of-range WRITE cycles and idle time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len      <= '0;
      idx      <= '0;
      bcnt     <= '0;
      sr       <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk      <= '0;
`endif
    end else begin
      if (start_ok) begin
        len  <= '0;
        idx  <= '0;
        bcnt <= '0;
        sr   <= '0;
        err  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk  <= '0;
`endif
      end
      if (accept) begin
        case (state)
          LEN_HI: len[15:8] <= ByteData;
          LEN_LO: begin
            len[7:0] <= ByteData;
            err      <= {16'h0, len_full} > DEPTH_U;
          end
          DATA: begin
            sr   <= {sr[15:0], ByteData};
            bcnt <= bcnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk  <= chk ^ ByteData;
`endif
            if (bcnt == 2'd3 && in_range) begin
              mem_addr <= BASE_ADDR + {14'h0, idx, 2'b00};
              mem_data <= {sr, ByteData};
            end
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          CHECK: err <= err | (chk != ByteData);
`endif
          default: ;
        endcase
      end
      if (state == WRITE) idx <= idx + 16'd1;
    end
  end

  assign MemWrite     = (state == WRITE) && in_range;
  assign MemAddress   = mem_addr;
  assign MemWriteData = mem_data;
  assign CpuHold      = (state == LEN_HI) || (state == LEN_LO) || (state == DATA) ||
                        (state == WRITE)  || (state == CHECK);
  assign Done         = (state == DONE);
  assign Error        = err;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: two instances (default and DEPTH=2 at base 0x1000)
// share one byte stream; monitors pop expected writes as MemWrite pulses.
module tb_imem_loader;
  logic        clk = 1'b0, reset = 1'b0, Start = 1'b0, ByteValid = 1'b0;
  logic [7:0]  ByteData = 8'h00;
  logic        a_ready, a_we, a_hold, a_done, a_err;
  logic        b_ready, b_we, b_hold, b_done, b_err;
  logic [31:0] a_addr, a_data, b_addr, b_data;

  imem_loader u_dut (
    .clk(clk), .reset(reset), .Start(Start), .ByteValid(ByteValid), .ByteData(ByteData),
    .ByteReady(a_ready), .MemWrite(a_we), .MemAddress(a_addr), .MemWriteData(a_data),
    .CpuHold(a_hold), .Done(a_done), .Error(a_err));

  imem_loader #(.BASE_ADDR(32'h0000_1000), .DEPTH(2)) u_ovf (
    .clk(clk), .reset(reset), .Start(Start), .ByteValid(ByteValid), .ByteData(ByteData),
    .ByteReady(b_ready), .MemWrite(b_we), .MemAddress(b_addr), .MemWriteData(b_data),
    .CpuHold(b_hold), .Done(b_done), .Error(b_err));

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t qa[$], qb[$];
  wr_t ea, eb;
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (a_we) begin
    if (qa.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL wr_a_unexpected: got addr %h data %h want no write", a_addr, a_data);
    end else begin
      ea = qa.pop_front();
      chk("wr_a_addr", a_addr, ea.addr);
      chk("wr_a_data", a_data, ea.data);
    end
  end

  always @(negedge clk) if (b_we) begin
    if (qb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL wr_b_unexpected: got addr %h data %h want no write", b_addr, b_data);
    end else begin
      eb = qb.pop_front();
      chk("wr_b_addr", b_addr, eb.addr);
      chk("wr_b_data", b_data, eb.data);
    end
  end

  task automatic pulse_start();
    @(negedge clk); Start = 1'b1;
    @(negedge clk); Start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    ByteValid = 1'b1; ByteData = b; n = 0;
    while (!a_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL byte_timeout: got ready 0 want 1 for byte %h", b);
    end
    @(posedge clk); #1 ByteValid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send(w[31:24], gap); send(w[23:16], gap); send(w[15:8], gap); send(w[7:0], gap);
  endtask

  task automatic push(input int idx, input logic [31:0] w);
    qa.push_back({32'(idx) << 2, w});
    if (idx < 2) qb.push_back({32'h1000 + (32'(idx) << 2), w});
  endtask

  task automatic send_chk(input logic [7:0] c);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(c, 0);
`else
    if (c === 8'hxx) send(c, 0);
`endif
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!a_done && n < 100) begin @(negedge clk); n++; end
    chk({name, "_done_a"}, a_done, 1'b1);
    chk({name, "_done_b"}, b_done, 1'b1);
    chk({name, "_hold"}, a_hold, 1'b0);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", a_ready, 0); chk("rst_we", a_we, 0); chk("rst_hold", a_hold, 0);
    chk("rst_done", a_done, 0); chk("rst_err", a_err, 0); chk("rst_addr", a_addr, 0);
    reset = 1'b1;

    // 1: reset mid-DATA after two data bytes
    pulse_start();
    chk("t1_hold", a_hold, 1);
    send(8'h00, 0); send(8'h01, 0); send(8'h20, 0); send(8'h04, 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("t1_hold_after", a_hold, 0); chk("t1_ready_after", a_ready, 0);
    chk("t1_done_after", a_done, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("t1_idle_ready", a_ready, 0);

    // 2: single word
    pulse_start();
    send(8'h00, 0); send(8'h01, 0);
    push(0, 32'h2004_0003);
    send_word(32'h2004_0003, 0);
    send_chk(8'h27);
    wait_done("t2");
    chk("t2_err_a", a_err, 0); chk("t2_err_b", b_err, 0);

    // 3/4: three words back to back; DEPTH=2 instance overflows
    pulse_start();
    chk("t3_done_clr", a_done, 0);
    send(8'h00, 0); send(8'h03, 0);
    push(0, 32'h0804_0003); push(1, 32'h0C00_0003); push(2, 32'h1000_FFFF);
    send_word(32'h0804_0003, 0); send_word(32'h0C00_0003, 0); send_word(32'h1000_FFFF, 0);
    send_chk(8'h10);
    wait_done("t3");
    chk("t3_err_a", a_err, 0); chk("t3_err_b", b_err, 1);
    chk("t3_addr_a", a_addr, 32'h8); chk("t3_addr_b", b_addr, 32'h1004);
    chk("t3_data_b", b_data, 32'h0C00_0003);

    // 5: ByteValid gaps, byte offered during WRITE, Start mid-load
    pulse_start();
    send(8'h00, 2); send(8'h02, 1);
    push(0, 32'hDEAD_BEEF); push(1, 32'h0123_4567);
    send_word(32'hDEAD_BEEF, 1);
    ByteValid = 1'b1; ByteData = 8'hAA;
    @(negedge clk); chk("t5_write_ready", a_ready, 0);
    @(posedge clk); #1 ByteValid = 1'b0;
    send(8'h01, 0);
    pulse_start();
    chk("t5_start_ignored_hold", a_hold, 1); chk("t5_start_ignored_done", a_done, 0);
    send(8'h23, 3); send(8'h45, 0); send(8'h67, 1);
    send_chk(8'h22);
    wait_done("t5");
    chk("t5_err_a", a_err, 0); chk("t5_err_b", b_err, 0);
    chk("t5_data_a", a_data, 32'h0123_4567);

    // N = 0: no writes
    pulse_start();
    send(8'h00, 0); send(8'h00, 0);
    send_chk(8'h00);
    wait_done("t0");
    chk("t0_err", a_err, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // 6: checksum good then bad
    pulse_start();
    send(8'h00, 0); send(8'h01, 0);
    push(0, 32'h1122_3344);
    send_word(32'h1122_3344, 0);
    send(8'h44, 0);
    wait_done("t6a");
    chk("t6_good_err", a_err, 0);
    pulse_start();
    send(8'h00, 0); send(8'h01, 0);
    push(0, 32'h1122_3344);
    send_word(32'h1122_3344, 0);
    send(8'h45, 0);
    wait_done("t6b");
    chk("t6_bad_err", a_err, 1);
`endif

    repeat (3) @(negedge clk);
    chk("q_a_empty", qa.size(), 0);
    chk("q_b_empty", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
